// File: rtl/stage_4_accumulate.sv
// Adds each float pair on one shared fp_add core and accumulates SAMPLES pair sums into result.
// Latency: start accepted at T gives done at T+2*ADD_LATENCY+2; one job in flight at a time.
// Busy starts are dropped, or held in a one-entry skid buffer when STAGE4_SKID_BUFFER_EN is defined.
module stage_4_accumulate #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int ADD_LATENCY      = 7,
    parameter int SAMPLES          = 4,
    parameter int COUNT_WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        start,
    input  logic [FLOAT_DATA_WIDTH-1:0] to_add_one,
    input  logic [FLOAT_DATA_WIDTH-1:0] to_add_two,
    input  logic                        acc_clear,
    output logic [FLOAT_DATA_WIDTH-1:0] result,
    output logic                        done,
    output logic                        working,
    output logic                        dropped
);
    localparam int W = FLOAT_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ADD_PAIR, ADD_ACC, DONE_CHK} state_t;

    state_t                 state, state_next;
    logic [COUNT_WIDTH-1:0] lat_cnt, count;
    logic [W-1:0]           op_one, op_two, pair_sum, acc;
    logic [W-1:0]           fp_a, fp_b, fp_comb, fp_sum;
    logic                   clear_pend, start_ok, lat_last, fp_en, accept, drop, pending;
`ifdef STAGE4_SKID_BUFFER_EN
    logic [W-1:0]           buf_one, buf_two;
    logic                   take_pend, buf_store;
`endif

    // IEEE-754 single add, round to nearest even; subnormals flush to zero.
    function automatic logic [31:0] fp_add32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        logic [27:0] mx, my, sum;
        logic [9:0]  ex;
        logic [7:0]  d;
        logic [22:0] mant;
        logic [24:0] mr;
        logic        sticky;
        r = 32'h0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0))
                r = 32'h7FC0_0000;
            else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])
                r = 32'h7FC0_0000;
            else
                r = (a[30:23] == 8'hFF) ? a : b;
        end else if (a[30:23] == 8'h00) begin
            r = (b[30:23] == 8'h00) ? {a[31] & b[31], 31'h0} : b;
        end else if (b[30:23] == 8'h00) begin
            r = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin x = a; y = b; end
            else begin x = b; y = a; end
            d      = x[30:23] - y[30:23];
            mx     = {2'b01, x[22:0], 3'b000};
            my     = {2'b01, y[22:0], 3'b000};
            sticky = 1'b0;
            for (int i = 0; i < 27; i++) begin
                if (i < int'(d)) begin
                    sticky = sticky | my[0];
                    my     = my >> 1;
                end
            end
            my[0] = my[0] | sticky;
            sum   = (x[31] == y[31]) ? mx + my : mx - my;
            ex    = {2'b00, x[30:23]};
            if (sum != 28'h0) begin
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                    ex  = ex + 10'd1;
                end else begin
                    for (int i = 0; i < 26; i++) begin
                        if (!sum[26]) begin
                            sum = sum << 1;
                            ex  = ex - 10'd1;
                        end
                    end
                end
                mant = sum[25:3];
                if (sum[2] && (sum[1] || sum[0] || sum[3])) begin
                    mr = {2'b01, mant} + 25'd1;
                    if (mr[24]) begin
                        mant = mr[23:1];
                        ex   = ex + 10'd1;
                    end else begin
                        mant = mr[22:0];
                    end
                end
                if (ex[9] || ex == 10'd0)  r = {x[31], 31'h0};
                else if (ex >= 10'd255)    r = {x[31], 8'hFF, 23'h0};
                else                       r = {x[31], ex[7:0], mant};
            end
        end
        return r;
    endfunction

    assign fp_a    = (state == ADD_ACC) ? pair_sum : op_one;
    assign fp_b    = (state == ADD_ACC) ? acc      : op_two;
    assign fp_comb = fp_add32(fp_a, fp_b);

    // The FSM's own capture register is the last of the ADD_LATENCY stages.
    generate
        if (ADD_LATENCY == 1) begin : g_lat1
            assign fp_sum = fp_comb;
        end else begin : g_pipe
            logic [W-1:0] pipe [ADD_LATENCY-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe <= '{default: '0};
                end else if (fp_en) begin
                    pipe[0] <= fp_comb;
                    for (int i = 1; i < ADD_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign fp_sum = pipe[ADD_LATENCY-2];
        end
    endgenerate

    assign start_ok = clk_en && start;
    assign lat_last = (lat_cnt == COUNT_WIDTH'(ADD_LATENCY - 1));
    assign working  = (state != IDLE) || pending;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fp_en      = 1'b0;
        drop       = 1'b0;
`ifdef STAGE4_SKID_BUFFER_EN
        take_pend  = 1'b0;
        buf_store  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_ok && !pending) begin
                    accept     = 1'b1;
                    state_next = ADD_PAIR;
                end
`ifdef STAGE4_SKID_BUFFER_EN
                if (pending) begin
                    take_pend  = 1'b1;
                    buf_store  = start_ok;
                    state_next = ADD_PAIR;
                end
`endif
            end
            ADD_PAIR: begin
                fp_en = 1'b1;
                if (lat_last) state_next = ADD_ACC;
            end
            ADD_ACC: begin
                fp_en = 1'b1;
                if (lat_last) state_next = DONE_CHK;
            end
            default: state_next = IDLE;
        endcase
        if (start_ok && state != IDLE) begin
`ifdef STAGE4_SKID_BUFFER_EN
            drop      = pending;
            buf_store = !pending;
`else
            drop      = 1'b1;
`endif
        end
    end

`ifdef STAGE4_SKID_BUFFER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            buf_one <= '0;
            buf_two <= '0;
        end else if (buf_store) begin
            pending <= 1'b1;
            buf_one <= to_add_one;
            buf_two <= to_add_two;
        end else if (take_pend) begin
            pending <= 1'b0;
        end
    end
`else
    assign pending = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            count      <= '0;
            op_one     <= '0;
            op_two     <= '0;
            pair_sum   <= '0;
            acc        <= '0;
            result     <= '0;
            done       <= 1'b0;
            dropped    <= 1'b0;
            clear_pend <= 1'b0;
        end else begin
            state   <= state_next;
            done    <= 1'b0;
            dropped <= drop;
            lat_cnt <= (fp_en && !lat_last) ? lat_cnt + 1'b1 : '0;
            if (accept) begin
                op_one <= to_add_one;
                op_two <= to_add_two;
            end
`ifdef STAGE4_SKID_BUFFER_EN
            else if (take_pend) begin
                op_one <= buf_one;
                op_two <= buf_two;
            end
`endif
            if (state == ADD_PAIR && lat_last) pair_sum <= fp_sum;
            if ((state == ADD_PAIR || state == ADD_ACC) && acc_clear) clear_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (acc_clear) begin
                        acc   <= '0;
                        count <= '0;
                    end
                end
                ADD_ACC: begin
                    if (lat_last) begin
                        acc   <= fp_sum;
                        count <= count + 1'b1;
                    end
                end
                DONE_CHK: begin
                    clear_pend <= 1'b0;
                    // A clear seen while busy discards the sample just accumulated.
                    if (clear_pend || acc_clear) begin
                        acc   <= '0;
                        count <= '0;
                    end else if (count == COUNT_WIDTH'(SAMPLES)) begin
                        result <= acc;
                        done   <= 1'b1;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_4_accumulate.sv
// Drives a SAMPLES=1 and a SAMPLES=4 instance with shared stimulus and checks both against a job-level model.
module tb_stage_4_accumulate;
    localparam int LAT = 5;
    localparam int SP  = 2 * LAT + 3;
`ifdef STAGE4_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clk_en, start, acc_clear;
    logic [31:0] to_add_one, to_add_two;
    logic [31:0] res [2];
    logic        dn [2], wk [2], dr [2];

    always #5 clk = ~clk;

    stage_4_accumulate #(.FLOAT_DATA_WIDTH(32), .ADD_LATENCY(LAT), .SAMPLES(1), .COUNT_WIDTH(8)) u_s1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .to_add_one(to_add_one),
        .to_add_two(to_add_two), .acc_clear(acc_clear), .result(res[0]), .done(dn[0]),
        .working(wk[0]), .dropped(dr[0]));

    stage_4_accumulate #(.FLOAT_DATA_WIDTH(32), .ADD_LATENCY(LAT), .SAMPLES(4), .COUNT_WIDTH(8)) u_s4 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .to_add_one(to_add_one),
        .to_add_two(to_add_two), .acc_clear(acc_clear), .result(res[1]), .done(dn[1]),
        .working(wk[1]), .dropped(dr[1]));

    int errors, checks, cyc;

    // Reference model: one job per instance, tracked by the cycle it frees the adder.
    int          free_at [2];
    bit          pv [2], cflag [2], job_on [2], drop_next [2];
    logic [31:0] pa [2], pb [2], done_val [2], res_hold [2];
    real         macc [2], job_sum [2];
    int          mcnt [2], done_at [2];

    int          done_cnt [2], drop_cnt [2], done_cyc [2];
    logic [31:0] last_res [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'h00) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real         m;
        int          e, fr;
        logic        s;
        logic [31:0] frb;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        fr  = $rtoi((m - 1.0) * 8388608.0);
        frb = 32'(fr);
        return {s, 8'(e + 127), frb[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        return r2f((real'($urandom_range(0, 16)) - 8.0) * 0.5);
    endfunction

    function automatic int samples_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic launch(input int k, input int c, input logic [31:0] a, input logic [31:0] b);
        job_on[k]  = 1'b1;
        job_sum[k] = f2r(a) + f2r(b);
        free_at[k] = c + 2 * LAT + 2;
    endtask

    task automatic model_step(input int c, input bit st, input logic [31:0] a, input logic [31:0] b,
                              input bit clr, input bit rs);
        for (int k = 0; k < 2; k++) begin
            drop_next[k] = 1'b0;
            if (rs) begin
                free_at[k] = 0; pv[k] = 1'b0; macc[k] = 0.0; mcnt[k] = 0; cflag[k] = 1'b0;
                job_on[k] = 1'b0; res_hold[k] = 32'h0; done_at[k] = -1;
            end else if (c < free_at[k]) begin
                if (clr) cflag[k] = 1'b1;
                if (job_on[k] && c == free_at[k] - 1) begin
                    job_on[k] = 1'b0;
                    if (cflag[k]) begin
                        macc[k] = 0.0; mcnt[k] = 0; cflag[k] = 1'b0;
                    end else begin
                        macc[k] = macc[k] + job_sum[k];
                        mcnt[k]++;
                        if (mcnt[k] == samples_of(k)) begin
                            done_at[k]  = c + 1;
                            done_val[k] = r2f(macc[k]);
                            macc[k]     = 0.0;
                            mcnt[k]     = 0;
                        end
                    end
                end
                if (st) begin
                    if (SKID && !pv[k]) begin pv[k] = 1'b1; pa[k] = a; pb[k] = b; end
                    else drop_next[k] = 1'b1;
                end
            end else begin
                if (clr) begin macc[k] = 0.0; mcnt[k] = 0; end
                if (pv[k]) begin
                    launch(k, c, pa[k], pb[k]);
                    if (st) begin pa[k] = a; pb[k] = b; end
                    else pv[k] = 1'b0;
                end else if (st) begin
                    launch(k, c, a, b);
                end
            end
        end
    endtask

    task automatic observe();
        bit ed, ew;
        for (int k = 0; k < 2; k++) begin
            if (dn[k]) begin done_cnt[k]++; last_res[k] = res[k]; done_cyc[k] = cyc; end
            if (dr[k]) drop_cnt[k]++;
            if (cyc > 0) begin
                ed = (done_at[k] == cyc);
                ew = (cyc < free_at[k]) || pv[k];
                if (ed) res_hold[k] = done_val[k];
                chk($sformatf("done[%0d]@%0d", k, cyc), 32'(dn[k]), 32'(ed));
                chk($sformatf("result[%0d]@%0d", k, cyc), res[k], res_hold[k]);
                chk($sformatf("dropped[%0d]@%0d", k, cyc), 32'(dr[k]), 32'(drop_next[k]));
                chk($sformatf("working[%0d]@%0d", k, cyc), 32'(wk[k]), 32'(ew));
            end
        end
    endtask

    task automatic tick(input bit st, input logic [31:0] a, input logic [31:0] b,
                        input bit clr, input bit rs, input bit ce);
        @(negedge clk);
        observe();
        rst = rs; clk_en = ce; start = st; to_add_one = a; to_add_two = b; acc_clear = clr;
        model_step(cyc, ce && st, a, b, clr, rs);
        cyc++;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        tick(1'b1, a, b, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int t0, d0, d1, r0;
        errors = 0; checks = 0; cyc = 0;
        rst = 1'b1; clk_en = 1'b0; start = 1'b0; acc_clear = 1'b0;
        to_add_one = 32'h0; to_add_two = 32'h0;
        for (int k = 0; k < 2; k++) begin
            done_at[k] = -1; done_cnt[k] = 0; drop_cnt[k] = 0; done_cyc[k] = 0; last_res[k] = 32'h0;
        end
        repeat (3) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_result[%0d]", k), res[k], 32'h0);
            chk($sformatf("rst_done[%0d]", k), 32'(dn[k]), 32'h0);
            chk($sformatf("rst_working[%0d]", k), 32'(wk[k]), 32'h0);
            chk($sformatf("rst_dropped[%0d]", k), 32'(dr[k]), 32'h0);
        end

        // 1.0 + 2.0 on SAMPLES=1
        t0 = cyc;
        send(32'h3F80_0000, 32'h4000_0000);
        idle_n(SP + 2);
        chk("t1_latency", 32'(done_cyc[0] - t0), 32'(2 * LAT + 2));
        chk("t1_result", last_res[0], 32'h4040_0000);

        // four samples of 0.5+0.5 on SAMPLES=4 after clearing the leftover sample
        tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        d1 = done_cnt[1];
        for (int i = 0; i < 4; i++) begin send(32'h3F00_0000, 32'h3F00_0000); idle_n(SP - 1); end
        idle_n(2);
        chk("t2_done_count", 32'(done_cnt[1] - d1), 32'd1);
        chk("t2_result", last_res[1], 32'h4080_0000);

        // two samples, idle clear, then a full fresh set
        d1 = done_cnt[1];
        for (int i = 0; i < 2; i++) begin send(32'h3F00_0000, 32'h3F00_0000); idle_n(SP - 1); end
        tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin send(32'h3F00_0000, 32'h3F00_0000); idle_n(SP - 1); end
        idle_n(2);
        chk("t3_done_count", 32'(done_cnt[1] - d1), 32'd1);
        chk("t3_result", last_res[1], 32'h4080_0000);

        // reset while the accumulate add is running
        send(32'h3F80_0000, 32'h3F80_0000);
        idle_n(LAT + 3);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle_n(1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t4_working[%0d]", k), 32'(wk[k]), 32'h0);
            chk($sformatf("t4_done[%0d]", k), 32'(dn[k]), 32'h0);
            chk($sformatf("t4_result[%0d]", k), res[k], 32'h0);
        end
        d0 = done_cnt[0];
        send(32'h3F80_0000, 32'h3F80_0000);
        idle_n(SP + 2);
        chk("t4_done_count", 32'(done_cnt[0] - d0), 32'd1);
        chk("t4_fresh_result", last_res[0], 32'h4000_0000);

        // two starts one cycle apart
        d0 = done_cnt[0]; r0 = drop_cnt[0];
        send(32'h3F80_0000, 32'h3F80_0000);
        send(32'h4000_0000, 32'h4000_0000);
        idle_n(2 * SP + 4);
        chk("t5_done_count", 32'(done_cnt[0] - d0), SKID ? 32'd2 : 32'd1);
        chk("t5_drops", 32'(drop_cnt[0] - r0), SKID ? 32'd0 : 32'd1);
        chk("t5_last_result", last_res[0], SKID ? 32'h4080_0000 : 32'h4000_0000);

        // three starts back to back
        r0 = drop_cnt[0];
        for (int i = 0; i < 3; i++) send(32'h3F80_0000, 32'h3F80_0000);
        idle_n(2 * SP + 4);
        chk("t6_drops", 32'(drop_cnt[0] - r0), SKID ? 32'd1 : 32'd2);

        // randomized traffic with occasional clears, gated starts and resets
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 5) == 0, rnd_op(), rnd_op(), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 599) == 0, $urandom_range(0, 4) != 0);
        end
        idle_n(2 * SP + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
